// File: rtl/rc4_pkg.sv
// Purpose: shared types, character constants and byte-validity rule for the RC4 decrypt path.
// Latency: n/a (package).
// Backpressure: n/a (package).
package rc4_pkg;

  localparam logic [7:0] CHAR_SPACE      = 8'h20;
  localparam logic [7:0] CHAR_LO         = 8'h61;
  localparam logic [7:0] CHAR_HI         = 8'h7A;
  localparam int         MSG_LEN_DEFAULT = 32;

  // One state per PRGA micro-step; WAIT_* states cover the 1-cycle RAM read latency.
  typedef enum logic [3:0] {
    ST_IDLE,
    ST_INC_I,
    ST_WAIT_SI,
    ST_LATCH_SI,
    ST_WAIT_SJ,
    ST_LATCH_SJ,
    ST_WR_SJ,
    ST_RD_F,
    ST_WAIT_F,
    ST_WR_DEC,
    ST_PASS,
    ST_FAIL
  } prga_state_t;

  // A plaintext byte is acceptable if it is a space or a lowercase letter.
  function automatic logic is_valid_char(input logic [7:0] c);
    return (c == CHAR_SPACE) || ((c >= CHAR_LO) && (c <= CHAR_HI));
  endfunction

endpackage

// File: rtl/rc4_char_check.sv
// Purpose: combinational plaintext byte check (space or a-z).
// Latency: 0 cycles, purely combinational.
// Backpressure: none.
module rc4_char_check
  import rc4_pkg::*;
(
  input  logic [7:0] char_dat,
  output logic       char_vld
);

  assign char_vld = is_valid_char(char_dat);

endmodule

// File: rtl/prga_decrypt_checker.sv
// Purpose: RC4 PRGA over the ciphertext ROM, writes plaintext RAM, verdict on byte validity.
// Latency: 9 cycles/byte, verdict 9*MSG_LEN+1 cycles after go (first bad byte ends it early under PRGA_EARLY_ABORT_EN).
// Backpressure: none; go low aborts to IDLE on the next edge, clearing outputs and enables.
module prga_decrypt_checker
  import rc4_pkg::*;
#(
  parameter int MSG_LEN = MSG_LEN_DEFAULT,
  parameter int ADDR_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              go,
  output logic [7:0]        s_addr,
  output logic [7:0]        s_wdata,
  output logic              s_wren,
  input  logic [7:0]        s_q,
  output logic [ADDR_W-1:0] enc_addr,
  input  logic [7:0]        enc_q,
  output logic [ADDR_W-1:0] dec_addr,
  output logic [7:0]        dec_wdata,
  output logic              dec_wren,
  output logic              success,
  output logic              failure
);

  prga_state_t       state_q, state_d;
  logic [7:0]        i_q, i_d, j_q, j_d, si_q, si_d, sj_q, sj_d;
  logic [ADDR_W-1:0] k_q, k_d;
  logic [7:0]        s_addr_q, s_addr_d, s_wdata_q, s_wdata_d;
  logic              s_wren_q, s_wren_d;
  logic [ADDR_W-1:0] enc_addr_q, enc_addr_d, dec_addr_q, dec_addr_d;
  logic [7:0]        dec_wdata_q, dec_wdata_d;
  logic              dec_wren_q, dec_wren_d;
  logic              success_q, success_d, failure_q, failure_d;
`ifndef PRGA_EARLY_ABORT_EN
  logic              bad_q, bad_d;
`endif

  logic [7:0] pt_dat;
  logic       pt_vld;
  logic       last_byte;

  // Keystream byte arrives on s_q in WR_DEC, ciphertext byte has been stable on enc_q since INC_I.
  assign pt_dat    = s_q ^ enc_q;
  assign last_byte = (k_q == ADDR_W'(MSG_LEN - 1));

  rc4_char_check u_char_check (
    .char_dat (pt_dat),
    .char_vld (pt_vld)
  );

  // Next-state and registered-output logic; each state's action appears on the ports one cycle later.
  always_comb begin
    state_d     = state_q;
    i_d         = i_q;
    j_d         = j_q;
    k_d         = k_q;
    si_d        = si_q;
    sj_d        = sj_q;
    s_addr_d    = s_addr_q;
    s_wdata_d   = s_wdata_q;
    s_wren_d    = 1'b0;
    enc_addr_d  = enc_addr_q;
    dec_addr_d  = dec_addr_q;
    dec_wdata_d = dec_wdata_q;
    dec_wren_d  = 1'b0;
    success_d   = 1'b0;
    failure_d   = 1'b0;
`ifndef PRGA_EARLY_ABORT_EN
    bad_d       = bad_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (go) begin
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
`ifndef PRGA_EARLY_ABORT_EN
          bad_d   = 1'b0;
`endif
          state_d = ST_INC_I;
        end
      end
      ST_INC_I: begin
        i_d        = i_q + 8'd1;
        s_addr_d   = i_q + 8'd1;
        enc_addr_d = k_q;
        state_d    = ST_WAIT_SI;
      end
      ST_WAIT_SI: state_d = ST_LATCH_SI;
      ST_LATCH_SI: begin
        si_d     = s_q;
        j_d      = j_q + s_q;
        s_addr_d = j_q + s_q;
        state_d  = ST_WAIT_SJ;
      end
      ST_WAIT_SJ: state_d = ST_LATCH_SJ;
      ST_LATCH_SJ: begin
        sj_d      = s_q;
        s_addr_d  = i_q;
        s_wdata_d = s_q;
        s_wren_d  = 1'b1;
        state_d   = ST_WR_SJ;
      end
      ST_WR_SJ: begin
        // When i == j both writes target one address and si == sj, so S[i] ends unchanged.
        s_addr_d  = j_q;
        s_wdata_d = si_q;
        s_wren_d  = 1'b1;
        state_d   = ST_RD_F;
      end
      ST_RD_F: begin
        s_addr_d = si_q + sj_q;
        state_d  = ST_WAIT_F;
      end
      ST_WAIT_F: state_d = ST_WR_DEC;
      ST_WR_DEC: begin
        dec_addr_d  = k_q;
        dec_wdata_d = pt_dat;
        dec_wren_d  = 1'b1;
`ifdef PRGA_EARLY_ABORT_EN
        if (!pt_vld) begin
          state_d = ST_FAIL;
        end else if (last_byte) begin
          state_d = ST_PASS;
        end else begin
          k_d     = k_q + ADDR_W'(1);
          state_d = ST_INC_I;
        end
`else
        // Keep decoding after a bad byte so per-key time is fixed and dec RAM holds the full dump.
        bad_d = bad_q | ~pt_vld;
        if (last_byte) begin
          state_d = bad_d ? ST_FAIL : ST_PASS;
        end else begin
          k_d     = k_q + ADDR_W'(1);
          state_d = ST_INC_I;
        end
`endif
      end
      ST_PASS: success_d = 1'b1;
      ST_FAIL: failure_d = 1'b1;
      default: state_d = ST_IDLE;
    endcase

    // Dropping go abandons the attempt: nothing queued in _d is allowed to reach the memories.
    if ((state_q != ST_IDLE) && !go) begin
      state_d     = ST_IDLE;
      s_addr_d    = '0;
      s_wdata_d   = '0;
      s_wren_d    = 1'b0;
      enc_addr_d  = '0;
      dec_addr_d  = '0;
      dec_wdata_d = '0;
      dec_wren_d  = 1'b0;
      success_d   = 1'b0;
      failure_d   = 1'b0;
    end
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      i_q         <= '0;
      j_q         <= '0;
      k_q         <= '0;
      si_q        <= '0;
      sj_q        <= '0;
      s_addr_q    <= '0;
      s_wdata_q   <= '0;
      s_wren_q    <= 1'b0;
      enc_addr_q  <= '0;
      dec_addr_q  <= '0;
      dec_wdata_q <= '0;
      dec_wren_q  <= 1'b0;
      success_q   <= 1'b0;
      failure_q   <= 1'b0;
`ifndef PRGA_EARLY_ABORT_EN
      bad_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      i_q         <= i_d;
      j_q         <= j_d;
      k_q         <= k_d;
      si_q        <= si_d;
      sj_q        <= sj_d;
      s_addr_q    <= s_addr_d;
      s_wdata_q   <= s_wdata_d;
      s_wren_q    <= s_wren_d;
      enc_addr_q  <= enc_addr_d;
      dec_addr_q  <= dec_addr_d;
      dec_wdata_q <= dec_wdata_d;
      dec_wren_q  <= dec_wren_d;
      success_q   <= success_d;
      failure_q   <= failure_d;
`ifndef PRGA_EARLY_ABORT_EN
      bad_q       <= bad_d;
`endif
    end
  end

  assign s_addr    = s_addr_q;
  assign s_wdata   = s_wdata_q;
  assign s_wren    = s_wren_q;
  assign enc_addr  = enc_addr_q;
  assign dec_addr  = dec_addr_q;
  assign dec_wdata = dec_wdata_q;
  assign dec_wren  = dec_wren_q;
  assign success   = success_q;
  assign failure   = failure_q;

endmodule
